crc_ram_dp_mem: RTL and testbench
=================================

Name: crc_ram_dp_mem

Overview:
Parametrised true-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) on a single clock. It is the successor to the fixed 256x8 CRC scratch RAM.
- Generalised in width and depth.
- Adds byte enables, selectable read latency with readdatavalid, deterministic write-collision arbitration, and a hardware clear sequencer.
- Sits between the CRC engine (s2) and the Nios/host bus (s1).

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8
ADDR_W, 8, word address width; DEPTH = 2**ADDR_W
RD_LATENCY, 1, read latency in cycles: 1 = unregistered q, 2 = output register; other values are illegal (elaboration error)
CLEAR_VAL, 0, word value written to every location by the clear sequencer

Ports:
clk  in  1  single clock for both ports
reset_n  in  1  asynchronous active-low reset
s1_address  in  ADDR_W  port 1 word address
s1_chipselect  in  1  port 1 select
s1_read  in  1  port 1 read strobe
s1_write  in  1  port 1 write strobe
s1_byteenable  in  DATA_W/8  port 1 byte lanes
s1_writedata  in  DATA_W  port 1 write data
s1_readdata  out  DATA_W  port 1 read data
s1_readdatavalid  out  1  port 1 read data valid
s1_waitrequest  out  1  port 1 stall
s2_* (same eight signals as s1)  port 2
clear_req  in  1  single-cycle request to clear the whole array
clear_busy  out  1  high while the clear sequence runs

Behaviour:
- Reset values:
  - readdata = 0, readdatavalid = 0 on both ports.
  - waitrequest = 1 on both ports, clear_busy = 1.
  - Clear FSM = CLEAR, clear address counter = 0.
  - Array contents are not reset by reset_n.
- Clear FSM, two states:
  - CLEAR: writes CLEAR_VAL to clr_addr, one word per cycle. clr_addr increments.
  - At clr_addr == DEPTH-1: the last word is written, then CLEAR -> IDLE on the next edge. Counter wraps to 0.
  - The clear takes exactly DEPTH cycles after reset_n deasserts.
  - IDLE: clear_req = 1 -> CLEAR with clr_addr = 0.
  - clear_req is ignored while in CLEAR.
  - reset_n asserted mid-clear restarts the clear from address 0.
- waitrequest = clear_busy = (state == CLEAR), combinational from state. No stalls in IDLE.
- A command is accepted when chipselect & (read | write) & ~waitrequest.
- read & write together: treated as a write only; no readdatavalid is produced.
- Writes: only lanes with byteenable = 1 are updated, in the accept cycle.
- Reads:
  - readdata is valid exactly RD_LATENCY cycles after the accept edge.
  - readdatavalid pulses high for one cycle aligned with the data.
  - readdata holds its last value when readdatavalid = 0.
  - Back-to-back reads are fully pipelined, one per cycle.
- Read-during-write, same address:
  - Same port: old data (read-first).
  - Mixed ports: old data.
- Write collision (both ports write the same address in the same cycle): s1 wins on every lane s1 enables. s2 writes only the lanes s1 leaves disabled.
- Reads accepted before a clear_req complete normally. Their readdatavalid still fires during CLEAR.

Optional Feature:
Macro: CRC_RAM_WRCRC_EN.
- Defined:
  - Adds output wr_crc [7:0]: a running CRC-8 (poly 0x07, init 0x00, MSB-first) over the enabled bytes of every accepted s2 write, lowest lane first, all lanes in one cycle.
  - wr_crc resets to 0x00 and is re-zeroed on entry to CLEAR.
  - Updated value is visible on the cycle after the write is accepted.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package crc_ram_pkg:
  - Clear FSM state enum (ST_IDLE, ST_CLEAR).
  - CRC8_POLY = 8'h07.
  - Function crc8_byte(crc, byte).
- One sub-module, crc_ram_rd_pipe: per-port read latency / readdatavalid shift stage, instantiated twice.
- Array, arbitration and clear FSM stay in the top module.

Test Plan:
- Reset release, DATA_W=8, ADDR_W=8, no activity:
  - waitrequest and clear_busy stay high for exactly 256 cycles, then drop.
  - Reads of addresses 0x00 and 0xFF return 0x00.
- RD_LATENCY=2, s1 writes 0xA5 to 0x10, then s2 reads 0x10 on three consecutive cycles:
  - s2_readdatavalid is high on cycles 2, 3 and 4 after the first read, each with 0xA5.
- DATA_W=32, word at 0x04 holds 0x11223344, s1 write 0xAABBCCDD with byteenable 4'b0101:
  - Readback returns 0x11BB33DD.
- Collision, DATA_W=16, same cycle at address 0x20:
  - s1 writes 0x1234 with be 2'b01; s2 writes 0xABCD with be 2'b11.
  - Readback returns 0xAB34.
- Mid-clear reset:
  - Assert clear_req, then pulse reset_n low 50 cycles into the clear.
  - clear_busy stays high for a full DEPTH cycles after release; all locations read CLEAR_VAL.
- CRC_RAM_WRCRC_EN defined:
  - s2 writes bytes 0x31..0x39 ("123456789") one per cycle → wr_crc = 0xF4.
  - clear_req → wr_crc = 0x00.

Source files
------------

// File: rtl/crc_ram_pkg.sv
// Shared types and CRC-8 helper for the dual-port CRC scratch RAM.
package crc_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One byte of MSB-first CRC-8, no reflection, no final xor.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_ram_rd_pipe.sv
// Per-port read return path: STAGES-deep valid/data shift, data held while idle.
module crc_ram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld
);

  logic [STAGES:1]             vld_q;
  logic [STAGES:1][DATA_W-1:0] dat_q;
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][DATA_W-1:0] dat_pipe;

  assign vld_pipe = {vld_q, rd_en};
  assign dat_pipe = {dat_q, rd_word};

  // Data stages only load behind a valid, so the last stage holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      for (int i = 1; i <= STAGES; i++) begin
        if (vld_pipe[i-1]) dat_q[i] <= dat_pipe[i-1];
      end
    end
  end

  assign rd_data = dat_pipe[STAGES];
  assign rd_vld  = vld_pipe[STAGES];

endmodule

// File: rtl/crc_ram_dp_mem.sv
// True dual-port Avalon-MM RAM with byte enables, s1-priority collisions and a clear sequencer.
// Optional running CRC-8 of s2 writes on wr_crc when CRC_RAM_WRCRC_EN is defined.
module crc_ram_dp_mem
  import crc_ram_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 8,
  parameter int                RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  input  logic                clear_req,
  output logic                clear_busy
`ifdef CRC_RAM_WRCRC_EN
  ,
  output logic [7:0]          wr_crc
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
    $error("crc_ram_dp_mem: DATA_W must be a non-zero multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("crc_ram_dp_mem: RD_LATENCY must be 1 or 2");
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rd_acc;
    logic              wr_acc;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata;
  } port_req_t;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              busy;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy       = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy       = 1'b1;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (&clr_addr_q) state_d = ST_IDLE;
      end
      default: begin
        if (clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
    endcase
  end

  assign s1_waitrequest = busy;
  assign s2_waitrequest = busy;
  assign clear_busy     = busy;

  // ---------------- command decode ----------------
  port_req_t [1:0] req;

  // read together with write is a write only
  always_comb begin
    req          = '0;
    req[0].addr   = s1_address;
    req[0].rd_acc = s1_chipselect & s1_read & ~s1_write & ~busy;
    req[0].wr_acc = s1_chipselect & s1_write & ~busy;
    req[0].be     = s1_byteenable;
    req[0].wdata  = s1_writedata;
    req[1].addr   = s2_address;
    req[1].rd_acc = s2_chipselect & s2_read & ~s2_write & ~busy;
    req[1].wr_acc = s2_chipselect & s2_write & ~busy;
    req[1].be     = s2_byteenable;
    req[1].wdata  = s2_writedata;
  end

  // s2 loses every lane s1 also writes at the same address
  logic [NB-1:0] s2_be_eff;
  assign s2_be_eff = (req[0].wr_acc && (req[0].addr == req[1].addr)) ?
                     (req[1].be & ~req[0].be) : req[1].be;

  // ---------------- array ----------------
  logic [NB-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr_q] <= CLEAR_VAL;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (req[0].wr_acc && req[0].be[b]) mem[req[0].addr][b] <= req[0].wdata[b*8 +: 8];
        if (req[1].wr_acc && s2_be_eff[b]) mem[req[1].addr][b] <= req[1].wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read return ----------------
  logic [1:0][DATA_W-1:0] rd_q;
  logic [1:0]             rd_vld;

  // Array is sampled at the accept edge, so reads see pre-write contents.
  for (genvar p = 0; p < 2; p++) begin : g_port
    crc_ram_rd_pipe #(
      .DATA_W (DATA_W),
      .STAGES (RD_LATENCY)
    ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (reset_n),
      .rd_en   (req[p].rd_acc),
      .rd_word (mem[req[p].addr]),
      .rd_data (rd_q[p]),
      .rd_vld  (rd_vld[p])
    );
  end

  assign s1_readdata      = rd_q[0];
  assign s1_readdatavalid = rd_vld[0];
  assign s2_readdata      = rd_q[1];
  assign s2_readdatavalid = rd_vld[1];

`ifdef CRC_RAM_WRCRC_EN
  // ---------------- s2 write CRC ----------------
  logic [7:0] crc_nxt;

  always_comb begin
    crc_nxt = wr_crc;
    for (int b = 0; b < NB; b++) begin
      if (req[1].be[b]) crc_nxt = crc8_byte(crc_nxt, req[1].wdata[b*8 +: 8]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             wr_crc <= '0;
    else if (state_q == ST_IDLE && clear_req) wr_crc <= '0;
    else if (req[1].wr_acc)                   wr_crc <= crc_nxt;
  end
`endif

endmodule

// File: tb/tb_crc_ram_dp_mem.sv
// Directed bench: A = 8-bit x 256, latency 1; B = 32-bit x 16, latency 2, non-zero clear value.
module tb_crc_ram_dp_mem;

  localparam logic [31:0] CV_B = 32'hC3C3_C3C3;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct packed {
    logic [7:0]  addr;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  req_t a1, a2, b1, b2;
  logic a_rst_n, b_rst_n, a_clr, b_clr;
  logic [7:0]  a1_rd, a2_rd;
  logic [31:0] b1_rd, b2_rd;
  logic a1_vld, a2_vld, a1_wait, a2_wait, a_busy;
  logic b1_vld, b2_vld, b1_wait, b2_wait, b_busy;
`ifdef CRC_RAM_WRCRC_EN
  logic [7:0] a_crc, b_crc;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n;
  int bad;

  crc_ram_dp_mem #(.DATA_W(8), .ADDR_W(8), .RD_LATENCY(1), .CLEAR_VAL(8'h00)) u_dut_a (
    .clk(gclk), .reset_n(a_rst_n),
    .s1_address(a1.addr), .s1_chipselect(a1.cs), .s1_read(a1.rd), .s1_write(a1.wr),
    .s1_byteenable(a1.be[0:0]), .s1_writedata(a1.wd[7:0]),
    .s1_readdata(a1_rd), .s1_readdatavalid(a1_vld), .s1_waitrequest(a1_wait),
    .s2_address(a2.addr), .s2_chipselect(a2.cs), .s2_read(a2.rd), .s2_write(a2.wr),
    .s2_byteenable(a2.be[0:0]), .s2_writedata(a2.wd[7:0]),
    .s2_readdata(a2_rd), .s2_readdatavalid(a2_vld), .s2_waitrequest(a2_wait),
    .clear_req(a_clr), .clear_busy(a_busy)
`ifdef CRC_RAM_WRCRC_EN
    , .wr_crc(a_crc)
`endif
  );

  crc_ram_dp_mem #(.DATA_W(32), .ADDR_W(4), .RD_LATENCY(2), .CLEAR_VAL(CV_B)) u_dut_b (
    .clk(gclk), .reset_n(b_rst_n),
    .s1_address(b1.addr[3:0]), .s1_chipselect(b1.cs), .s1_read(b1.rd), .s1_write(b1.wr),
    .s1_byteenable(b1.be), .s1_writedata(b1.wd),
    .s1_readdata(b1_rd), .s1_readdatavalid(b1_vld), .s1_waitrequest(b1_wait),
    .s2_address(b2.addr[3:0]), .s2_chipselect(b2.cs), .s2_read(b2.rd), .s2_write(b2.wr),
    .s2_byteenable(b2.be), .s2_writedata(b2.wd),
    .s2_readdata(b2_rd), .s2_readdatavalid(b2_vld), .s2_waitrequest(b2_wait),
    .clear_req(b_clr), .clear_busy(b_busy)
`ifdef CRC_RAM_WRCRC_EN
    , .wr_crc(b_crc)
`endif
  );

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  function automatic req_t mk(input logic [7:0] addr, input logic rd, input logic wr,
                              input logic [3:0] be, input logic [31:0] wd);
    return '{addr: addr, cs: 1'b1, rd: rd, wr: wr, be: be, wd: wd};
  endfunction

  task automatic idle();
    a1 = '0; a2 = '0; b1 = '0; b2 = '0;
  endtask

  task automatic wait_clear(input bit sel_b, output int cnt);
    cnt = 0;
    while ((sel_b ? b_busy : a_busy) && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic a_write(input bit port, input logic [7:0] addr, input logic [7:0] d);
    if (port) a2 = mk(addr, 1'b0, 1'b1, 4'h1, {24'h0, d});
    else      a1 = mk(addr, 1'b0, 1'b1, 4'h1, {24'h0, d});
    tick();
    idle();
  endtask

  task automatic a_read(input bit port, input logic [7:0] addr, input logic [7:0] exp, input string tag);
    if (port) a2 = mk(addr, 1'b1, 1'b0, 4'h0, 32'h0);
    else      a1 = mk(addr, 1'b1, 1'b0, 4'h0, 32'h0);
    tick();
    idle();
    chk({tag, " vld"}, port ? a2_vld : a1_vld, 1'b1);
    chk(tag, port ? a2_rd : a1_rd, exp);
  endtask

  task automatic b_write(input bit port, input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
    if (port) b2 = mk(addr, 1'b0, 1'b1, be, d);
    else      b1 = mk(addr, 1'b0, 1'b1, be, d);
    tick();
    idle();
  endtask

  task automatic b_read(input bit port, input logic [7:0] addr, input logic [31:0] exp, input string tag);
    if (port) b2 = mk(addr, 1'b1, 1'b0, 4'h0, 32'h0);
    else      b1 = mk(addr, 1'b1, 1'b0, 4'h0, 32'h0);
    tick();
    idle();
    chk({tag, " early"}, port ? b2_vld : b1_vld, 1'b0);
    tick();
    chk({tag, " vld"}, port ? b2_vld : b1_vld, 1'b1);
    chk(tag, port ? b2_rd : b1_rd, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    a_clr = 1'b0; b_clr = 1'b0;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    #2;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    repeat (3) tick();

    // ---------------- reset state ----------------
    chk("a rst wait", {a1_wait, a2_wait}, 2'b11);
    chk("a rst busy", a_busy, 1'b1);
    chk("a rst vld", {a1_vld, a2_vld}, 2'b00);
    chk("a rst rdata", {a1_rd, a2_rd}, 16'h0);
    chk("b rst wait", {b1_wait, b2_wait, b_busy}, 3'b111);
    chk("b rst rdata", b1_rd | b2_rd, 32'h0);
    chk("b rst vld", {b1_vld, b2_vld}, 2'b00);

    a_rst_n = 1'b1;
    wait_clear(1'b0, n);
    chk("a clr len rst", n, 256);
    chk("a wait idle", {a1_wait, a2_wait}, 2'b00);
    a_read(1'b0, 8'h00, 8'h00, "a rd 00");
    a_read(1'b1, 8'hFF, 8'h00, "a rd ff");

`ifdef CRC_RAM_WRCRC_EN
    chk("a crc rst", a_crc, 8'h00);
    for (int i = 0; i < 9; i++) begin
      a2 = mk(8'(128 + i), 1'b0, 1'b1, 4'h1, 32'(49 + i));
      tick();
      if (i == 0) chk("a crc 1", a_crc, 8'h97);
    end
    idle();
    chk("a crc 123456789", a_crc, 8'hF4);
`endif

    // ---------------- basic access, hold, RDW ----------------
    a_write(1'b1, 8'h33, 8'h5A);
    a_read(1'b0, 8'h33, 8'h5A, "a wr rd");
    tick();
    chk("a vld drop", a1_vld, 1'b0);
    chk("a rd hold", a1_rd, 8'h5A);

    a1 = mk(8'h33, 1'b0, 1'b1, 4'h1, 32'h77);
    a2 = mk(8'h33, 1'b1, 1'b0, 4'h0, 32'h0);
    tick();
    idle();
    chk("a rdw vld", a2_vld, 1'b1);
    chk("a rdw old", a2_rd, 8'h5A);
    a_read(1'b1, 8'h33, 8'h77, "a rdw new");

    a1 = mk(8'h40, 1'b1, 1'b1, 4'h1, 32'h99);
    tick();
    idle();
    chk("a rd+wr no vld", a1_vld, 1'b0);
    a_read(1'b0, 8'h40, 8'h99, "a rd+wr data");

    a1 = '{addr: 8'h40, cs: 1'b0, rd: 1'b0, wr: 1'b1, be: 4'h1, wd: 32'h11};
    tick();
    a1 = mk(8'h40, 1'b0, 1'b1, 4'h0, 32'h22);
    tick();
    idle();
    a_read(1'b0, 8'h40, 8'h99, "a cs0 be0 ignored");

    // ---------------- clear_req, then mid-clear reset ----------------
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("a clr busy", {a_busy, a1_wait}, 2'b11);
`ifdef CRC_RAM_WRCRC_EN
    chk("a crc cleared", a_crc, 8'h00);
`endif
    wait_clear(1'b0, n);
    chk("a clr len req", n, 256);
    a_read(1'b0, 8'h33, 8'h00, "a clr 33");
    a_read(1'b1, 8'h40, 8'h00, "a clr 40");

    a_write(1'b0, 8'h33, 8'h66);
    a_write(1'b1, 8'hFE, 8'h44);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    repeat (50) tick();
    a_rst_n = 1'b0;
    tick();
    chk("a midrst busy", a_busy, 1'b1);
    a_rst_n = 1'b1;
    wait_clear(1'b0, n);
    chk("a clr len midrst", n, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      a1 = mk(8'(i), 1'b1, 1'b0, 4'h0, 32'h0);
      tick();
      if (a1_vld !== 1'b1 || a1_rd !== 8'h00) bad++;
    end
    idle();
    chk("a all clear", bad, 0);

    // ---------------- instance B ----------------
    b_rst_n = 1'b1;
    wait_clear(1'b1, n);
    chk("b clr len rst", n, 16);
    b_read(1'b0, 8'h0, CV_B, "b rd clrval 0");
    b_read(1'b1, 8'hF, CV_B, "b rd clrval f");

`ifdef CRC_RAM_WRCRC_EN
    chk("b crc rst", b_crc, 8'h00);
    b_write(1'b1, 8'h9, 32'h0000_3231, 4'b0011);
    chk("b crc 2 lanes", b_crc, 8'h72);
`endif

    b_write(1'b0, 8'h5, 32'h0000_00A5, 4'hF);
    b_write(1'b1, 8'h6, 32'h1122_3344, 4'hF);
    b2 = mk(8'h5, 1'b1, 1'b0, 4'h0, 32'h0);
    tick();
    chk("b pipe c1 vld", b2_vld, 1'b0);
    b2 = mk(8'h6, 1'b1, 1'b0, 4'h0, 32'h0);
    tick();
    chk("b pipe c2 vld", b2_vld, 1'b1);
    chk("b pipe c2", b2_rd, 32'h0000_00A5);
    b2 = mk(8'h5, 1'b1, 1'b0, 4'h0, 32'h0);
    tick();
    idle();
    chk("b pipe c3 vld", b2_vld, 1'b1);
    chk("b pipe c3", b2_rd, 32'h1122_3344);
    tick();
    chk("b pipe c4 vld", b2_vld, 1'b1);
    chk("b pipe c4", b2_rd, 32'h0000_00A5);
    tick();
    chk("b pipe c5 vld", b2_vld, 1'b0);
    chk("b pipe hold", b2_rd, 32'h0000_00A5);

    b1 = mk(8'h5, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF);
    b2 = mk(8'h5, 1'b1, 1'b0, 4'h0, 32'h0);
    tick();
    idle();
    tick();
    chk("b rdw vld", b2_vld, 1'b1);
    chk("b rdw old", b2_rd, 32'h0000_00A5);
    b_read(1'b0, 8'h5, 32'hDEAD_BEEF, "b rdw new");

    b_write(1'b0, 8'h6, 32'hAABB_CCDD, 4'b0101);
    b_read(1'b1, 8'h6, 32'h11BB_33DD, "b byteen");

    b1 = mk(8'h2, 1'b0, 1'b1, 4'b0101, 32'h1111_1234);
    b2 = mk(8'h2, 1'b0, 1'b1, 4'b0011, 32'hEEEE_ABCD);
    tick();
    idle();
    b_read(1'b0, 8'h2, 32'hC311_AB34, "b collision");

    b1 = mk(8'h3, 1'b0, 1'b1, 4'hF, 32'h0102_0304);
    b2 = mk(8'h4, 1'b0, 1'b1, 4'hF, 32'h0A0B_0C0D);
    tick();
    idle();
    b_read(1'b1, 8'h3, 32'h0102_0304, "b dual wr 3");
    b_read(1'b0, 8'h4, 32'h0A0B_0C0D, "b dual wr 4");

    // read accepted with clear_req completes inside the clear; writes stall meanwhile
    b1 = mk(8'h6, 1'b1, 1'b0, 4'h0, 32'h0);
    b_clr = 1'b1;
    tick();
    idle();
    b_clr = 1'b0;
    chk("b clr busy", b_busy, 1'b1);
    chk("b clr rd early", b1_vld, 1'b0);
    tick();
    chk("b clr rd vld", {b1_vld, b_busy}, 2'b11);
    chk("b clr rd data", b1_rd, 32'h11BB_33DD);
    b1 = mk(8'h0, 1'b0, 1'b1, 4'hF, 32'h1234_5678);
    chk("b clr wait", b1_wait, 1'b1);
    tick();
    idle();
    wait_clear(1'b1, n);
    chk("b clr len req", n, 14);
    b_read(1'b0, 8'h0, CV_B, "b wr blocked");
    b_read(1'b1, 8'h6, CV_B, "b clr 6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
